// File: rtl/i2s_rx_stream.sv
// Captures completed stereo frames from an I2S master at a fixed delay after each ws falling edge,
// buffers them in a FWFT FIFO and streams them out. Optional drop counter: I2S_RX_DROP_CNT_EN.
module i2s_rx_stream #(
  parameter int DATA_WIDTH  = 24,
  parameter int CAPTURE_DLY = 512,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          arstn,
  input  logic                          ws,
  input  logic [DATA_WIDTH-1:0]         data_recv_left,
  input  logic [DATA_WIDTH-1:0]         data_recv_right,
  // Stream: a frame transfers on every cycle with m_valid & m_ready; m_valid and the
  // head data stay stable until that transfer, and m_valid never depends on m_ready.
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [DATA_WIDTH-1:0]         m_left,
  output logic [DATA_WIDTH-1:0]         m_right,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          overflow_clr,
`ifdef I2S_RX_DROP_CNT_EN
  output logic [15:0]                   drop_count,
`endif
  output logic                          dbg_cap_busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [15:0] DLY_M1 = 16'(CAPTURE_DLY - 1);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic {S_IDLE, S_BUSY} cap_state_t;

  cap_state_t state;
  logic [15:0] cnt;
  logic        ws_d;
  logic        primed;
  logic        fall;
  logic        cap_stb;

  assign fall    = ws_d & ~ws;
  assign cap_stb = (state == S_BUSY) && (cnt == 16'd0);
  assign dbg_cap_busy = (state == S_BUSY);

  // The first edge after reset only primes: the frame in flight then is incomplete.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state  <= S_IDLE;
      cnt    <= 16'd0;
      ws_d   <= 1'b1;
      primed <= 1'b0;
    end else begin
      ws_d <= ws;
      if (fall && !primed) primed <= 1'b1;
      if (fall && primed) begin
        state <= S_BUSY;
        cnt   <= DLY_M1;
      end else if (state == S_BUSY) begin
        if (cnt == 16'd0) state <= S_IDLE;
        else              cnt   <= cnt - 16'd1;
      end
    end
  end

  logic [2*DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [2*DATA_WIDTH-1:0] head;
  logic [AW-1:0]           wptr;
  logic [AW-1:0]           rptr;
  logic [AW:0]             level;
  logic                    full;
  logic                    pop;
  logic                    push_ok;
  logic                    drop;

  assign full    = (level == FULL_LVL);
  assign m_valid = (level != '0);
  assign pop     = m_valid & m_ready;
  // A full FIFO still takes the frame when the head leaves in the same cycle.
  assign push_ok = cap_stb & (~full | pop);
  assign drop    = cap_stb & full & ~pop;
  assign head    = mem[rptr];
  assign m_left  = m_valid ? head[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
  assign m_right = m_valid ? head[DATA_WIDTH-1:0] : '0;
  assign fifo_level = level;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= {data_recv_left, data_recv_right};
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      unique case ({push_ok, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // A drop wins over a simultaneous clear so the loss is never hidden.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn)            overflow <= 1'b0;
    else if (drop)         overflow <= 1'b1;
    else if (overflow_clr) overflow <= 1'b0;
  end

`ifdef I2S_RX_DROP_CNT_EN
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn)                            drop_count <= 16'd0;
    else if (overflow_clr)                 drop_count <= drop ? 16'd1 : 16'd0;
    else if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_i2s_rx_stream.sv
// Directed + randomized bench for i2s_rx_stream against a frame-level queue model.
module tb_i2s_rx_stream;

  localparam int DW    = 24;
  localparam int D     = 8;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            arstn = 1'b0;
  logic            ws = 1'b1;
  logic [DW-1:0]   data_recv_left = '0;
  logic [DW-1:0]   data_recv_right = '0;
  logic            m_valid;
  logic            m_ready = 1'b1;
  logic [DW-1:0]   m_left;
  logic [DW-1:0]   m_right;
  logic [2:0]      fifo_level;
  logic            overflow;
  logic            overflow_clr = 1'b0;
  logic            dbg_cap_busy;
`ifdef I2S_RX_DROP_CNT_EN
  logic [15:0]     drop_count;
`endif

  int checks = 0;
  int errors = 0;
  bit toggle_rdy = 1'b0;
  bit rand_rdy = 1'b0;

  always #5 clk = ~clk;

  i2s_rx_stream #(.DATA_WIDTH(DW), .CAPTURE_DLY(D), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .arstn(arstn), .ws(ws),
    .data_recv_left(data_recv_left), .data_recv_right(data_recv_right),
    .m_valid(m_valid), .m_ready(m_ready), .m_left(m_left), .m_right(m_right),
    .fifo_level(fifo_level), .overflow(overflow), .overflow_clr(overflow_clr),
`ifdef I2S_RX_DROP_CNT_EN
    .drop_count(drop_count),
`endif
    .dbg_cap_busy(dbg_cap_busy)
  );

  // Frame-level reference: a capture is due D clocks after a primed falling edge.
  logic [2*DW-1:0] exp_q[$];
  bit m_ovf = 1'b0;
  bit m_primed = 1'b0;
  bit m_pend = 1'b0;
  bit m_prev_ws = 1'b1;
  int m_drops = 0;
  int cyc = 0;
  int deadline = 0;

  always @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      exp_q.delete();
      m_ovf = 1'b0; m_primed = 1'b0; m_pend = 1'b0; m_prev_ws = 1'b1; m_drops = 0;
    end else begin
      bit do_pop, was_full, capture, dropped;
      cyc++;
      do_pop   = (exp_q.size() != 0) && m_ready;
      was_full = (exp_q.size() == DEPTH);
      capture  = m_pend && (cyc == deadline);
      dropped  = 1'b0;
      if (do_pop) void'(exp_q.pop_front());
      if (capture) begin
        if (!was_full || do_pop) exp_q.push_back({data_recv_left, data_recv_right});
        else dropped = 1'b1;
        m_pend = 1'b0;
      end
      if (dropped) m_ovf = 1'b1;
      else if (overflow_clr) m_ovf = 1'b0;
      if (overflow_clr) m_drops = dropped ? 1 : 0;
      else if (dropped && m_drops < 65535) m_drops++;
      if (m_prev_ws && !ws) begin
        if (m_primed) begin
          m_pend = 1'b1;
          deadline = cyc + D;
        end else m_primed = 1'b1;
      end
      m_prev_ws = ws;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("m_valid", 64'(m_valid), 64'(exp_q.size() != 0));
    chk("fifo_level", 64'(fifo_level), 64'(exp_q.size()));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("cap_busy", 64'(dbg_cap_busy), 64'(m_pend));
    if (exp_q.size() != 0) begin
      chk("m_left", 64'(m_left), 64'(exp_q[0][2*DW-1:DW]));
      chk("m_right", 64'(m_right), 64'(exp_q[0][DW-1:0]));
    end else begin
      chk("m_left_idle", 64'(m_left), 64'd0);
      chk("m_right_idle", 64'(m_right), 64'd0);
    end
`ifdef I2S_RX_DROP_CNT_EN
    chk("drop_count", 64'(drop_count), 64'(m_drops));
`endif
  endtask

  task automatic step();
    @(negedge clk);
    check_all();
    if (toggle_rdy) m_ready = ~m_ready;
    if (rand_rdy) begin
      m_ready = 1'($urandom_range(0, 1));
      overflow_clr = ($urandom_range(0, 15) == 0);
    end
  endtask

  task automatic frame_d(input logic [DW-1:0] l, input logic [DW-1:0] r, input int lo, input int hi);
    data_recv_left = l;
    data_recv_right = r;
    ws = 1'b0;
    repeat (lo) step();
    ws = 1'b1;
    repeat (hi) step();
  endtask

  task automatic frame_rand();
    frame_d(DW'($urandom), DW'($urandom), 12, 12);
  endtask

  initial begin
    // Reset state
    repeat (3) step();
    @(negedge clk);
    arstn = 1'b1;
    repeat (2) step();

    // First edge only primes; second gives a frame D+1 clocks later
    frame_d(24'h123456, 24'habcdef, 12, 12);
    frame_d(24'h123456, 24'habcdef, 12, 12);

    // Overflow: five frames into a four-deep FIFO with no consumer
    m_ready = 1'b0;
    repeat (5) frame_rand();
    chk("level_full", 64'(fifo_level), 64'd4);
    chk("overflow_set", 64'(overflow), 64'd1);
    m_ready = 1'b1;
    repeat (6) step();
    overflow_clr = 1'b1;
    step();
    overflow_clr = 1'b0;
    step();

    // Full FIFO with a pop coinciding with the capture strobe
    m_ready = 1'b0;
    repeat (4) frame_rand();
    data_recv_left = DW'($urandom);
    data_recv_right = DW'($urandom);
    ws = 1'b0;
    repeat (D) step();
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    chk("level_coincident", 64'(fifo_level), 64'd4);
    chk("overflow_coincident", 64'(overflow), 64'd0);
    repeat (4) step();
    ws = 1'b1;
    m_ready = 1'b1;
    repeat (8) step();

    // Backpressure toggling every cycle
    toggle_rdy = 1'b1;
    repeat (3) frame_rand();
    toggle_rdy = 1'b0;
    m_ready = 1'b1;
    repeat (6) step();

    // Second falling edge 3 cycles after the first: a single capture
    data_recv_left = DW'($urandom);
    data_recv_right = DW'($urandom);
    ws = 1'b0;
    step();
    ws = 1'b1;
    step();
    step();
    ws = 1'b0;
    repeat (12) step();
    ws = 1'b1;
    repeat (12) step();

    // Reset while busy with two frames stored
    m_ready = 1'b0;
    repeat (2) frame_rand();
    ws = 1'b0;
    repeat (4) step();
    @(negedge clk);
    arstn = 1'b0;
    #1;
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    ws = 1'b1;
    repeat (2) step();
    @(negedge clk);
    arstn = 1'b1;
    m_ready = 1'b1;
    repeat (2) step();
    frame_rand();
    chk("reprime_empty", 64'(fifo_level), 64'd0);
    repeat (2) frame_rand();

    // Randomized ready and clear traffic
    rand_rdy = 1'b1;
    for (int i = 0; i < 20; i++) frame_d(DW'($urandom), DW'($urandom),
                                         $urandom_range(10, 14), $urandom_range(10, 14));
    rand_rdy = 1'b0;
    overflow_clr = 1'b0;
    m_ready = 1'b1;
    repeat (8) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
